audio_i2s_tx: RTL and testbench

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

---
 rtl/audio_i2s_tx_if.sv | 9 +
 rtl/audio_i2s_tx.sv | 122 ++++++++++++
 tb/tb_audio_i2s_tx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/audio_i2s_tx_if.sv
// PCM frame input bus for audio_i2s_tx: one-cycle strobe plus a stereo pair of signed 16-bit samples.
interface audio_i2s_tx_if;
    logic        in_stb;
    logic [15:0] in_left;
    logic [15:0] in_right;

    modport master (output in_stb, output in_left, output in_right);
    modport slave  (input  in_stb, input  in_left, input  in_right);
endinterface

// File: rtl/audio_i2s_tx.sv
// Stereo frame FIFO feeding an I2S serializer (bclk = clk / (2*BCLK_DIV), 32 slots per frame, MSB first).
// Optional feature macro AUDIO_I2S_UNDERRUN_CNT_EN adds a saturating 8-bit underrun counter output.
module audio_i2s_tx #(
    parameter int DEPTH    = 4,
    parameter int BCLK_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    audio_i2s_tx_if.slave            pcm,
    output logic                     bclk,
    output logic                     lrclk,
    output logic                     sdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underrun
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    ,
    output logic [7:0]               underrun_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

    logic [DW-1:0] div;
    logic [4:0]    f;
    logic [4:0]    f_nxt;
    logic [31:0]   w;
    logic [31:0]   w_nxt;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic tick;
    logic fall;
    logic pop;
    logic empty;
    logic full;
    logic do_pop;
    logic do_push;

    always_comb begin
        tick    = (div == DW'(BCLK_DIV - 1));
        fall    = tick && bclk;
        pop     = fall && (f == 5'd31);
        empty   = (level == '0);
        full    = (level == LW'(DEPTH));
        do_pop  = pop && !empty;
        // A pop in the same cycle frees a slot, so a full FIFO can still take the write.
        do_push = pcm.in_stb && (!full || do_pop);
        f_nxt   = f + 5'd1;
        w_nxt   = w;
        if (pop) begin
            w_nxt = empty ? 32'd0 : mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {pcm.in_left, pcm.in_right};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            bclk     <= 1'b0;
            f        <= 5'd31;
            w        <= '0;
            sdata    <= 1'b0;
            lrclk    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (tick) begin
                div  <= '0;
                bclk <= ~bclk;
            end else begin
                div  <= div + DW'(1);
            end

            if (fall) begin
                f     <= f_nxt;
                w     <= w_nxt;
                sdata <= w_nxt[5'd31 - f_nxt];
                // Word select changes one slot ahead of the data it announces.
                lrclk <= (f_nxt >= 5'd15) && (f_nxt != 5'd31);
            end

            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            overflow <= pcm.in_stb && !do_push;
            underrun <= pop && empty;
        end
    end

`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (pop && empty && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Randomized bench for audio_i2s_tx against a cycle-count and queue based frame model.
module tb_audio_i2s_tx;

    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int FR    = 64 * D;
    localparam int POPPH = 2 * D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bclk, lrclk, sdata, overflow, underrun;
    logic [$clog2(DEPTH):0] level;
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    logic [7:0] underrun_cnt;
`endif

    audio_i2s_tx_if ifc();

    audio_i2s_tx #(.DEPTH(DEPTH), .BCLK_DIV(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .pcm      (ifc),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .level    (level),
        .overflow (overflow),
        .underrun (underrun)
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    bit chk_en = 0;

    // Model state: n = clk edges since reset release, q = queued frames, mw = frame being serialized.
    int          n = 0;
    logic [31:0] q[$];
    logic [31:0] mw = '0;
    bit          e_ovf = 0;
    bit          e_und = 0;
    int          ucnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d, t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            n = 0;
            q.delete();
            mw = '0;
            e_ovf = 0;
            e_und = 0;
            ucnt = 0;
        end else begin
            n++;
            e_ovf = 0;
            e_und = 0;
            if ((n % POPPH == 0) && (((n / POPPH) - 1) % 32 == 0)) begin
                if (q.size() == 0) begin
                    mw = '0;
                    e_und = 1;
                    if (ucnt < 255) ucnt++;
                end else begin
                    mw = q.pop_front();
                end
            end
            if (ifc.in_stb) begin
                if (q.size() < DEPTH) q.push_back({ifc.in_left, ifc.in_right});
                else e_ovf = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            int k;
            int s;
            logic exp_lr;
            logic exp_sd;
            k = n / POPPH;
            exp_lr = 1'b0;
            exp_sd = 1'b0;
            if (k > 0) begin
                s = (k - 1) % 32;
                exp_lr = (s >= 15) && (s <= 30);
                exp_sd = mw[31 - s];
            end
            chk("bclk", 32'(bclk), 32'((n / D) % 2));
            chk("lrclk", 32'(lrclk), 32'(exp_lr));
            chk("sdata", 32'(sdata), 32'(exp_sd));
            chk("level", 32'(level), 32'(q.size()));
            chk("overflow", 32'(overflow), 32'(e_ovf));
            chk("underrun", 32'(underrun), 32'(e_und));
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
            chk("underrun_cnt", 32'(underrun_cnt), 32'(ucnt));
`endif
        end
    end

    // Call at a negedge; strobes for exactly the next edge.
    task automatic stb_now(input logic [15:0] l, input logic [15:0] r);
        ifc.in_stb   = 1'b1;
        ifc.in_left  = l;
        ifc.in_right = r;
        @(negedge clk);
        ifc.in_stb   = 1'b0;
    endtask

    task automatic wr(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        stb_now(l, r);
    endtask

    // Returns at the negedge just before the edge whose index mod FR equals ph.
    task automatic wait_ph(input int ph);
        for (int i = 0; i < FR + 8; i++) begin
            if (!rst && ((n + 1) % FR == ph)) return;
            @(negedge clk);
        end
        chk("wait_phase_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        ifc.in_stb   = 1'b0;
        ifc.in_left  = '0;
        ifc.in_right = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1;
        rst = 1'b0;

        // Idle: silent frames with an underrun per frame.
        repeat (2 * FR) @(negedge clk);

        // Single asymmetric frame.
        wait_ph(POPPH + 3);
        stb_now(16'h8001, 16'h7FFE);
        repeat (2 * FR) @(negedge clk);

        // Five writes between pops: one dropped, four replayed.
        wait_ph(POPPH + 3);
        for (int i = 0; i < 5; i++) wr(16'h1000 + 16'(i), 16'hA000 + 16'(i));
        repeat (6 * FR) @(negedge clk);

        // Fill, then strobe on the pop edge itself.
        wait_ph(POPPH + 3);
        for (int i = 0; i < 4; i++) wr(16'h2000 + 16'(i), 16'hB000 + 16'(i));
        wait_ph(POPPH);
        stb_now(16'h2CCC, 16'hBCCC);
        repeat (6 * FR) @(negedge clk);

        // Random traffic, occasionally bursty enough to overflow.
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 79) == 0 || ($urandom_range(0, 999) == 0)) begin
                ifc.in_stb   = 1'b1;
                ifc.in_left  = 16'($urandom);
                ifc.in_right = 16'($urandom);
            end else begin
                ifc.in_stb   = 1'b0;
            end
        end
        @(negedge clk);
        ifc.in_stb = 1'b0;
        repeat (6 * FR) @(negedge clk);

        // Reset mid-frame at slot 20 with three frames queued.
        wait_ph(POPPH + 3);
        for (int i = 0; i < 3; i++) wr(16'h3000 + 16'(i), 16'hC000 + 16'(i));
        wait_ph(POPPH * 21 + 2);
        chk("level_before_rst", 32'(level), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("level_in_rst", 32'(level), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_ph(POPPH + 3);
        wr(16'h5A5A, 16'hA5A5);
        repeat (3 * FR) @(negedge clk);

`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
        repeat (260 * FR) @(negedge clk);
        chk("underrun_cnt_sat", 32'(underrun_cnt), 32'd255);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("underrun_cnt_rst", 32'(underrun_cnt), 32'd0);
        rst = 1'b0;
        repeat (FR) @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
